generatore_scansione: RTL and testbench

GENERATORE_SCANSIONE -- requirements
Module: generatore_scansione

---
 rtl/generatore_scansione.sv | 151 +++++++++++++++
 tb/tb_generatore_scansione.sv | 134 +++++++++++++
 2 files changed

// File: rtl/generatore_scansione.sv
// Raster scan generator with a bouncing-object position tracker.
// Latency: scan outputs are registered decodes of the counters, one cycle behind them.
// Backpressure: none; free-running at the pixel clock, and positions update once per frame.
module generatore_scansione #(
    parameter int H          = 1280,
    parameter int H_FP       = 48,
    parameter int H_SYNC     = 112,
    parameter int H_TOT      = 1688,
    parameter int V          = 1024,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_TOT      = 1066,
    parameter int altezza    = 100,
    parameter int X_INIZIALE = 590,
    parameter int Y_INIZIALE = 462
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE_MOTO,
    input  logic [3:0]  PASSO_X,
    input  logic [3:0]  PASSO_Y,
    output logic [10:0] X_CONTROLLO,
    output logic [10:0] Y_CONTROLLO,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        VISIBILE,
    output logic        FINE_QUADRO,
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS
);

    // Decode constants sized to the 11-bit counters so every compare is width-matched.
    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS    = 11'(H);
    localparam logic [10:0] V_VIS    = 11'(V);
    localparam logic [10:0] HS_START = 11'(H + H_FP);
    localparam logic [10:0] HS_END   = 11'(H + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V + V_FP);
    localparam logic [10:0] VS_END   = 11'(V + V_FP + V_SYNC - 1);
    localparam logic [11:0] H_WRAP   = 12'(H);
    localparam logic [11:0] Y_BOTTOM = 12'(V - altezza);
    localparam logic [10:0] X_RESET  = 11'(X_INIZIALE);
    localparam logic [10:0] Y_RESET  = 11'(Y_INIZIALE);

    logic [10:0] cnt_x_q, cnt_x_d;
    logic [10:0] cnt_y_q, cnt_y_d;
    logic [10:0] x_ctrl_q, y_ctrl_q;
    logic        hsync_q, vsync_q, visibile_q, fine_q;
    logic [10:0] x_pos_q, x_pos_d;
    logic [10:0] y_pos_q, y_pos_d;
    logic        dir_q, dir_d;   // 0 = moving down, 1 = moving up

    logic        fine_riga;
    logic [11:0] somma_x, diff_x, somma_y;

    assign fine_riga = (cnt_x_q == H_LAST);
    assign somma_x   = {1'b0, x_pos_q} + {8'd0, PASSO_X};
    assign diff_x    = somma_x - H_WRAP;
    assign somma_y   = {1'b0, y_pos_q} + {8'd0, PASSO_Y};

    // Column counter wraps every line; line counter advances only on the column wrap.
    always_comb begin
        cnt_x_d = fine_riga ? 11'd0 : cnt_x_q + 11'd1;
        cnt_y_d = cnt_y_q;
        if (fine_riga) begin
            cnt_y_d = (cnt_y_q == V_LAST) ? 11'd0 : cnt_y_q + 11'd1;
        end
    end

    // Counter state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_x_q <= 11'd0;
            cnt_y_q <= 11'd0;
        end else begin
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
        end
    end

    // Registered scan decodes, all derived from the same counter snapshot so they stay aligned.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_ctrl_q   <= 11'd0;
            y_ctrl_q   <= 11'd0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            visibile_q <= 1'b0;
            fine_q     <= 1'b0;
        end else begin
            x_ctrl_q   <= cnt_x_q;
            y_ctrl_q   <= cnt_y_q;
            hsync_q    <= (cnt_x_q >= HS_START) && (cnt_x_q <= HS_END);
            vsync_q    <= (cnt_y_q >= VS_START) && (cnt_y_q <= VS_END);
            visibile_q <= (cnt_x_q < H_VIS) && (cnt_y_q < V_VIS);
            fine_q     <= fine_riga && (cnt_y_q == V_LAST);
        end
    end

    // Object motion, evaluated only on the edge that ends the last pixel of a frame,
    // so positions stay constant across every visible frame.
    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dir_d   = dir_q;
        if (fine_q && ENABLE_MOTO) begin
            x_pos_d = (somma_x >= H_WRAP) ? diff_x[10:0] : somma_x[10:0];
            if (!dir_q) begin
                // Moving down: clamp at the lower bound and turn around.
                if (somma_y >= Y_BOTTOM) begin
                    y_pos_d = Y_BOTTOM[10:0];
                    dir_d   = 1'b1;
                end else begin
                    y_pos_d = somma_y[10:0];
                end
            end else begin
                // Moving up: clamp at the top and turn around.
                if (y_pos_q <= {7'd0, PASSO_Y}) begin
                    y_pos_d = 11'd0;
                    dir_d   = 1'b0;
                end else begin
                    y_pos_d = y_pos_q - {7'd0, PASSO_Y};
                end
            end
        end
    end

    // Position and direction state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_pos_q <= X_RESET;
            y_pos_q <= Y_RESET;
            dir_q   <= 1'b0;
        end else begin
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            dir_q   <= dir_d;
        end
    end

    assign X_CONTROLLO = x_ctrl_q;
    assign Y_CONTROLLO = y_ctrl_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign VISIBILE    = visibile_q;
    assign FINE_QUADRO = fine_q;
    assign X_POS       = x_pos_q;
    assign Y_POS       = y_pos_q;

endmodule

// File: tb/tb_generatore_scansione.sv
// Directed bench for the scan generator using a shrunken raster so whole frames fit.
// Geometry: 24 x 14 total, 16 x 10 visible, HSYNC cols 18..20, VSYNC lines 11..12, frame 336 cycles.
// Object: start (12,3), lower bound 10-3 = 7, X wraps at 16.
module tb_generatore_scansione;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE_MOTO;
    logic [3:0]  PASSO_X;
    logic [3:0]  PASSO_Y;
    logic [10:0] X_CONTROLLO;
    logic [10:0] Y_CONTROLLO;
    logic        HSYNC;
    logic        VSYNC;
    logic        VISIBILE;
    logic        FINE_QUADRO;
    logic [10:0] X_POS;
    logic [10:0] Y_POS;

    int n_test = 0;
    int n_fail = 0;

    generatore_scansione #(
        .H(16), .H_FP(2), .H_SYNC(3), .H_TOT(24),
        .V(10), .V_FP(1), .V_SYNC(2), .V_TOT(14),
        .altezza(3), .X_INIZIALE(12), .Y_INIZIALE(3)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE_MOTO(ENABLE_MOTO),
        .PASSO_X(PASSO_X), .PASSO_Y(PASSO_Y),
        .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .VISIBILE(VISIBILE), .FINE_QUADRO(FINE_QUADRO),
        .X_POS(X_POS), .Y_POS(Y_POS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_test++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hand-computed object position held during each frame (en/step table below).
    int exp_xp [8] = '{12, 3, 10, 10, 10, 1, 8, 15};
    int exp_yp [8] = '{ 3, 6,  7,  7,  4, 1, 0,  3};
    // Per-frame stimulus applied at that frame's closing edge.
    int tab_en [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    int tab_px [8] = '{7, 7, 7, 0, 7, 7, 7, 7};
    int tab_py [8] = '{3, 3, 3, 3, 3, 3, 3, 3};

    localparam int FRAME = 336;

    initial begin
        int hs_cnt, vs_cnt, fq_cnt;
        int ex, ey, f, ph;
        hs_cnt = 0; vs_cnt = 0; fq_cnt = 0;

        RESET_N     = 1'b0;
        ENABLE_MOTO = 1'b1;
        PASSO_X     = 4'd7;
        PASSO_Y     = 4'd3;
        repeat (3) @(negedge CLK);

        chk("rst_x",   int'(X_CONTROLLO), 0);
        chk("rst_y",   int'(Y_CONTROLLO), 0);
        chk("rst_vis", int'(VISIBILE), 0);
        chk("rst_fq",  int'(FINE_QUADRO), 0);
        chk("rst_xp",  int'(X_POS), 12);
        chk("rst_yp",  int'(Y_POS), 3);

        RESET_N = 1'b1;

        for (int k = 0; k < 8 * FRAME; k++) begin
            @(negedge CLK);
            f  = k / FRAME;
            ph = k % FRAME;
            ex = k % 24;
            ey = (k / 24) % 14;
            chk($sformatf("xc@%0d", k), int'(X_CONTROLLO), ex);
            chk($sformatf("yc@%0d", k), int'(Y_CONTROLLO), ey);
            chk($sformatf("hs@%0d", k), int'(HSYNC), (ex >= 18 && ex <= 20) ? 1 : 0);
            chk($sformatf("vs@%0d", k), int'(VSYNC), (ey >= 11 && ey <= 12) ? 1 : 0);
            chk($sformatf("vis@%0d", k), int'(VISIBILE), (ex < 16 && ey < 10) ? 1 : 0);
            chk($sformatf("fq@%0d", k), int'(FINE_QUADRO), (ex == 23 && ey == 13) ? 1 : 0);
            chk($sformatf("xp@%0d", k), int'(X_POS), exp_xp[f]);
            chk($sformatf("yp@%0d", k), int'(Y_POS), exp_yp[f]);
            if (f == 0) begin
                hs_cnt += int'(HSYNC);
                vs_cnt += int'(VSYNC);
                fq_cnt += int'(FINE_QUADRO);
                if (ph == FRAME - 1) begin
                    chk("hs_per_frame", hs_cnt, 42);
                    chk("vs_per_frame", vs_cnt, 48);
                    chk("fq_per_frame", fq_cnt, 1);
                end
            end
            // Drive inputs for the edge that ends this cycle; frame 2 pulses enable mid-frame only.
            ENABLE_MOTO = tab_en[f][0];
            if (f == 2 && ph >= 100 && ph < 200) ENABLE_MOTO = 1'b1;
            // Frame 3: step is briefly nonzero mid-frame, must not matter at the frame end.
            PASSO_X = 4'(tab_px[f]);
            if (f == 3 && ph >= 50 && ph < 60) PASSO_X = 4'd5;
            PASSO_Y = 4'(tab_py[f]);
        end

        // Asynchronous reset mid-line, between clock edges.
        while (X_CONTROLLO != 11'd10) @(negedge CLK);
        chk("pre_arst_x", int'(X_CONTROLLO), 10);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_x",   int'(X_CONTROLLO), 0);
        chk("arst_y",   int'(Y_CONTROLLO), 0);
        chk("arst_hs",  int'(HSYNC), 0);
        chk("arst_vs",  int'(VSYNC), 0);
        chk("arst_vis", int'(VISIBILE), 0);
        chk("arst_xp",  int'(X_POS), 12);
        chk("arst_yp",  int'(Y_POS), 3);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rel_x",   int'(X_CONTROLLO), 0);
        chk("rel_y",   int'(Y_CONTROLLO), 0);
        chk("rel_vis", int'(VISIBILE), 1);
        @(negedge CLK);
        chk("rel_x1",  int'(X_CONTROLLO), 1);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
